// File: rtl/iigs_shadow_ctrl.sv
// IIgs memory-side controller: fast/ROM/slow decode, shadow-write FIFO
// replayed into slow RAM at the 1 MHz slot rate, and stalled E0/E1 access.
module iigs_shadow_ctrl #(
    parameter int RAMSIZE  = 20,
    parameter int SLOW_DIV = 14,
    parameter int FIFO_AW  = 2
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               fast_ce,
    input  logic [7:0]         bank,
    input  logic [15:0]        addr,
    input  logic               we,
    input  logic [7:0]         dout,
    input  logic [7:0]         shadow,
    input  logic               io,
    input  logic               rdrom,
    input  logic               lc_we,
    output logic               cpu_wait,
    output logic               fastram_ce,
    output logic               rom_ce,
    output logic [7:0]         slow_rdata,
    output logic [16:0]        slowram_addr,
    output logic [7:0]         slowram_din,
    output logic               slowram_we,
    output logic               slowram_ce,
    input  logic [7:0]         slowram_q,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int CW    = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {
        IDLE,
        SLOW_PEND,
        SLOW_DONE
    } state_t;

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    state_t              state_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                cpu_wait_q;
    logic [7:0]          slow_rdata_q;
    logic [16:0]         lat_addr_q;
    logic                lat_we_q;
    logic [7:0]          lat_dout_q;

    logic [24:0]         fifo_mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]    count_q, count_d;
    logic                hold_q, hold_d;
    logic [24:0]         hold_data_q, hold_data_d;

    // ---------------------------------------------------------------
    // Address decode
    // ---------------------------------------------------------------
    logic in_0400, in_0800, in_2000, in_4000, in_2000_9fff;
    logic bank_lo, bank_01, lc_hi_wr, direct_slow, shadow_hit;

    // Combinational bus decode and shadow-region match
    always_comb begin
        rom_ce = (bank == 8'hFE) || (bank == 8'hFF)
              || ((bank == 8'h00) && (addr >= 16'hC100) && rdrom);

        lc_hi_wr = lc_we && we && (addr >= 16'hD000);

        fastram_ce = (bank < 8'(RAMSIZE)) && !io && (!rom_ce || lc_hi_wr);

        direct_slow = (bank[7:1] == 7'h70) && !io;

        bank_lo = (bank[7:1] == 7'h00);
        bank_01 = (bank == 8'h01);

        in_0400      = (addr[15:10] == 6'b000001);
        in_0800      = (addr[15:10] == 6'b000010);
        in_2000      = (addr[15:13] == 3'b001);
        in_4000      = (addr[15:13] == 3'b010);
        in_2000_9fff = (addr >= 16'h2000) && (addr <= 16'h9FFF);

        shadow_hit = we && bank_lo && fastram_ce && (
              (in_0400 && !shadow[0])
           || (in_0800 && !shadow[5])
           || (in_2000 && !shadow[1] && (!bank_01 || !shadow[4]))
           || (in_4000 && !shadow[2] && (!bank_01 || !shadow[4]))
           || (bank_01 && in_2000_9fff && !shadow[3]));
    end

    // ---------------------------------------------------------------
    // Slot timing and FIFO control
    // ---------------------------------------------------------------
    logic        slot, fifo_full, fifo_empty;
    logic        cpu_acc, new_hit, hold_set;
    logic        enq_new, enq_hold, enq, deq, cpu_issue;
    logic [24:0] new_entry, enq_data, head;

    // Per-cycle event decisions shared by the FIFO and the state machine
    always_comb begin
        slot       = (cnt_q == CW'(SLOW_DIV - 1));
        fifo_full  = (count_q == (FIFO_AW + 1)'(DEPTH));
        fifo_empty = (count_q == '0);
        head       = fifo_mem[rd_ptr_q];

        cpu_acc  = fast_ce && !cpu_wait_q;
        new_hit  = cpu_acc && shadow_hit;
        enq_new  = new_hit && !fifo_full;
        hold_set = new_hit && fifo_full;

        deq = slot && !fifo_empty && (state_q != SLOW_DONE);

        enq_hold = hold_q && (!fifo_full || deq);
        enq      = enq_new || enq_hold;

        new_entry = {bank[0], addr, dout};
        enq_data  = enq_hold ? hold_data_q : new_entry;

        cpu_issue = slot && fifo_empty && (state_q == SLOW_PEND);
    end

    // Slot counter, pointers, level and held-entry next state
    always_comb begin
        cnt_d       = slot ? '0 : cnt_q + CW'(1);
        wr_ptr_d    = enq ? wr_ptr_q + FIFO_AW'(1) : wr_ptr_q;
        rd_ptr_d    = deq ? rd_ptr_q + FIFO_AW'(1) : rd_ptr_q;
        count_d     = count_q;
        hold_d      = hold_q;
        hold_data_d = hold_data_q;

        unique case ({enq, deq})
            2'b10:   count_d = count_q + (FIFO_AW + 1)'(1);
            2'b01:   count_d = count_q - (FIFO_AW + 1)'(1);
            default: count_d = count_q;
        endcase

        if (hold_set) begin
            hold_d      = 1'b1;
            hold_data_d = new_entry;
        end else if (enq_hold) begin
            hold_d = 1'b0;
        end
    end

    // Slot counter and FIFO bookkeeping registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_q      <= 1'b0;
            hold_data_q <= '0;
        end else begin
            cnt_q       <= cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hold_q      <= hold_d;
            hold_data_q <= hold_data_d;
        end
    end

    // Shadow FIFO storage; contents are don't-care until written
    always_ff @(posedge clk_sys) begin
        if (enq) begin
            fifo_mem[wr_ptr_q] <= enq_data;
        end
    end

    // ---------------------------------------------------------------
    // Slow-access state machine
    // ---------------------------------------------------------------
    // Tracks the stalled direct access and owns cpu_wait / read data
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cpu_wait_q   <= 1'b0;
            slow_rdata_q <= '0;
            lat_addr_q   <= '0;
            lat_we_q     <= 1'b0;
            lat_dout_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_acc && direct_slow) begin
                        lat_addr_q <= {bank[0], addr};
                        lat_we_q   <= we;
                        lat_dout_q <= dout;
                        cpu_wait_q <= 1'b1;
                        state_q    <= SLOW_PEND;
                    end else if (hold_set) begin
                        cpu_wait_q <= 1'b1;
                    end else if (enq_hold) begin
                        cpu_wait_q <= 1'b0;
                    end
                end
                SLOW_PEND: begin
                    if (cpu_issue) begin
                        state_q <= SLOW_DONE;
                    end
                end
                SLOW_DONE: begin
                    if (!lat_we_q) begin
                        slow_rdata_q <= slowram_q;
                    end
                    cpu_wait_q <= 1'b0;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Slow RAM port: one strobe per slot, idle bus parked at zero
    always_comb begin
        slowram_ce   = deq || cpu_issue;
        slowram_we   = deq || (cpu_issue && lat_we_q);
        slowram_addr = '0;
        slowram_din  = '0;
        if (deq) begin
            slowram_addr = head[24:8];
            slowram_din  = head[7:0];
        end else if (cpu_issue) begin
            slowram_addr = lat_addr_q;
            slowram_din  = lat_dout_q;
        end
    end

    assign cpu_wait   = cpu_wait_q;
    assign slow_rdata = slow_rdata_q;
    assign fifo_level = count_q;

endmodule

// File: tb/tb_iigs_shadow_ctrl.sv
// Directed scoreboard bench for iigs_shadow_ctrl.
// Slow-RAM accesses are checked in order against an expectation queue.
module tb_iigs_shadow_ctrl;

    localparam int DIV = 14;
    localparam int AW  = 2;
    localparam int RS  = 20;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          fast_ce;
    logic [7:0]    bank;
    logic [15:0]   addr;
    logic          we;
    logic [7:0]    dout;
    logic [7:0]    shadow;
    logic          io;
    logic          rdrom;
    logic          lc_we;
    logic          cpu_wait;
    logic          fastram_ce;
    logic          rom_ce;
    logic [7:0]    slow_rdata;
    logic [16:0]   slowram_addr;
    logic [7:0]    slowram_din;
    logic          slowram_we;
    logic          slowram_ce;
    logic [7:0]    slowram_q;
    logic [AW:0]   fifo_level;

    int n_tests = 0;
    int n_fail  = 0;

    logic [25:0] sb [$];
    logic [7:0]  smem [0:131071];

    iigs_shadow_ctrl #(
        .RAMSIZE  (RS),
        .SLOW_DIV (DIV),
        .FIFO_AW  (AW)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .fast_ce      (fast_ce),
        .bank         (bank),
        .addr         (addr),
        .we           (we),
        .dout         (dout),
        .shadow       (shadow),
        .io           (io),
        .rdrom        (rdrom),
        .lc_we        (lc_we),
        .cpu_wait     (cpu_wait),
        .fastram_ce   (fastram_ce),
        .rom_ce       (rom_ce),
        .slow_rdata   (slow_rdata),
        .slowram_addr (slowram_addr),
        .slowram_din  (slowram_din),
        .slowram_we   (slowram_we),
        .slowram_ce   (slowram_ce),
        .slowram_q    (slowram_q),
        .fifo_level   (fifo_level)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Slow RAM model: read data valid the cycle after the strobe
    always @(posedge clk_sys) begin
        if (slowram_ce) begin
            if (slowram_we) smem[slowram_addr] <= slowram_din;
            else slowram_q <= smem[slowram_addr];
        end
    end

    // Scoreboard: each slow strobe must match the oldest expectation
    always @(negedge clk_sys) begin
        if (reset_n === 1'b1 && slowram_ce === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_extra observed=%0h expected=none",
                       {slowram_we, slowram_addr, slowram_din});
            end else begin
                logic [25:0] e;
                logic [25:0] o;
                e = sb.pop_front();
                o = {slowram_we, slowram_addr,
                     slowram_we ? slowram_din : 8'h00};
                check("slow_access", 32'(o), 32'(e));
            end
        end
    end

    function automatic logic [25:0] ex(input logic w, input logic [7:0] b,
                                       input logic [15:0] a,
                                       input logic [7:0] d);
        return {w, b[0], a, w ? d : 8'h00};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        fast_ce = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;
    endtask

    task automatic cpu_acc(input logic [7:0] b, input logic [15:0] a,
                           input logic w, input logic [7:0] d);
        bank = b; addr = a; we = w; dout = d; fast_ce = 1'b1;
        @(posedge clk_sys);
        #1 fast_ce = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk_sys);
            n++;
        end
        #1;
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    task automatic wait_ready(input int budget, output int cyc);
        cyc = 0;
        while (cpu_wait && cyc < budget) begin
            @(posedge clk_sys);
            #1 cyc++;
        end
    endtask

    initial begin
        int cyc;
        for (int i = 0; i < 131072; i++) smem[i] = 8'h00;
        slowram_q = 8'h00;
        reset_n = 1'b0; fast_ce = 1'b0; bank = 8'h00; addr = 16'h0000;
        we = 1'b0; dout = 8'h00; shadow = 8'hFF; io = 1'b0;
        rdrom = 1'b0; lc_we = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        check("rst_wait", 32'(cpu_wait), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ce", 32'(slowram_ce), 32'd0);
        check("rst_we", 32'(slowram_we), 32'd0);
        check("rst_addr", 32'(slowram_addr), 32'd0);
        check("rst_din", 32'(slowram_din), 32'd0);
        check("rst_rdata", 32'(slow_rdata), 32'd0);

        // Mid SLOW_PEND reset with three queued writes
        reset_n = 1'b1;
        shadow = 8'h00;
        cpu_acc(8'h00, 16'h0400, 1'b1, 8'h01);
        cpu_acc(8'h00, 16'h0401, 1'b1, 8'h02);
        cpu_acc(8'h00, 16'h0402, 1'b1, 8'h03);
        cpu_acc(8'hE0, 16'h0000, 1'b0, 8'h00);
        check("pend_level", 32'(fifo_level), 32'd3);
        check("pend_wait", 32'(cpu_wait), 32'd1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_wait", 32'(cpu_wait), 32'd0);
        check("mid_rst_level", 32'(fifo_level), 32'd0);
        check("mid_rst_ce", 32'(slowram_ce), 32'd0);
        do_reset();

        // Single shadowed text-page write
        shadow = 8'h00;
        bank = 8'h00; addr = 16'h0400; we = 1'b1; dout = 8'h5A;
        fast_ce = 1'b1;
        #1;
        check("t2_fast_ce", 32'(fastram_ce), 32'd1);
        check("t2_rom_ce", 32'(rom_ce), 32'd0);
        sb.push_back(ex(1'b1, 8'h00, 16'h0400, 8'h5A));
        @(posedge clk_sys);
        #1 fast_ce = 1'b0;
        check("t2_nowait", 32'(cpu_wait), 32'd0);
        check("t2_level", 32'(fifo_level), 32'd1);
        wait_drain("t2_drain", DIV + 2);
        check("t2_level0", 32'(fifo_level), 32'd0);

        // Inhibited text page, inhibited hires, SHR-only bank 01 path
        shadow = 8'h01;
        cpu_acc(8'h00, 16'h0400, 1'b1, 8'h11);
        check("t3_inhibit_txt", 32'(fifo_level), 32'd0);
        shadow = 8'h02;
        cpu_acc(8'h00, 16'h2000, 1'b1, 8'h22);
        check("t3_inhibit_hgr", 32'(fifo_level), 32'd0);
        shadow = 8'h10;
        sb.push_back(ex(1'b1, 8'h01, 16'h2000, 8'h77));
        cpu_acc(8'h01, 16'h2000, 1'b1, 8'h77);
        check("t3_shr_level", 32'(fifo_level), 32'd1);
        wait_drain("t3_drain", DIV + 2);

        // Five back-to-back writes overflow a depth-4 FIFO
        do_reset();
        shadow = 8'h00;
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ex(1'b1, 8'h00, 16'h0400 + 16'(i), 8'hC0 + 8'(i)));
            cpu_acc(8'h00, 16'h0400 + 16'(i), 1'b1, 8'hC0 + 8'(i));
            if (i == 3) begin
                check("t4_level4", 32'(fifo_level), 32'd4);
                check("t4_nowait4", 32'(cpu_wait), 32'd0);
            end
        end
        check("t4_wait5", 32'(cpu_wait), 32'd1);
        check("t4_level_full", 32'(fifo_level), 32'd4);
        wait_ready(2 * DIV, cyc);
        check("t4_wait_drop", 32'(cpu_wait), 32'd0);
        check("t4_level_after", 32'(fifo_level), 32'd4);
        wait_drain("t4_drain", 6 * DIV);

        // Two queued writes then a stalled direct read of E1:2000
        do_reset();
        shadow = 8'h00;
        sb.push_back(ex(1'b1, 8'h00, 16'h0400, 8'hA1));
        cpu_acc(8'h00, 16'h0400, 1'b1, 8'hA1);
        sb.push_back(ex(1'b1, 8'h01, 16'h2000, 8'hB2));
        cpu_acc(8'h01, 16'h2000, 1'b1, 8'hB2);
        check("t5_level2", 32'(fifo_level), 32'd2);
        sb.push_back(ex(1'b0, 8'hE1, 16'h2000, 8'h00));
        cpu_acc(8'hE1, 16'h2000, 1'b0, 8'h00);
        check("t5_wait_hi", 32'(cpu_wait), 32'd1);
        wait_ready(4 * DIV, cyc);
        check("t5_wait_lo", 32'(cpu_wait), 32'd0);
        check("t5_lat_range",
              32'((cyc >= 2 * DIV) && (cyc <= 3 * DIV + 1)), 32'd1);
        check("t5_rdata", 32'(slow_rdata), 32'hB2);
        check("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Direct write then read back through E0
        sb.push_back(ex(1'b1, 8'hE0, 16'h1234, 8'h3C));
        cpu_acc(8'hE0, 16'h1234, 1'b1, 8'h3C);
        wait_ready(2 * DIV + 2, cyc);
        check("t5b_wr_done", 32'(cpu_wait), 32'd0);
        sb.push_back(ex(1'b0, 8'hE0, 16'h1234, 8'h00));
        cpu_acc(8'hE0, 16'h1234, 1'b0, 8'h00);
        wait_ready(2 * DIV + 2, cyc);
        check("t5b_rd_done", 32'(cpu_wait), 32'd0);
        check("t5b_rdata", 32'(slow_rdata), 32'h3C);

        // Combinational decode corners
        fast_ce = 1'b0;
        bank = 8'h00; addr = 16'hD000; we = 1'b1; rdrom = 1'b1;
        lc_we = 1'b1; io = 1'b0;
        #1;
        check("dec_lc_rom", 32'(rom_ce), 32'd1);
        check("dec_lc_fast", 32'(fastram_ce), 32'd1);
        lc_we = 1'b0;
        #1;
        check("dec_rom_only", 32'(fastram_ce), 32'd0);
        rdrom = 1'b0; bank = 8'(RS); addr = 16'h1000;
        #1;
        check("dec_ramsize", 32'(fastram_ce), 32'd0);
        bank = 8'(RS - 1);
        #1;
        check("dec_ramtop", 32'(fastram_ce), 32'd1);
        bank = 8'hFE;
        #1;
        check("dec_fe_rom", 32'(rom_ce), 32'd1);
        check("dec_fe_fast", 32'(fastram_ce), 32'd0);
        bank = 8'h00; addr = 16'hC050; io = 1'b1;
        #1;
        check("dec_io", 32'(fastram_ce), 32'd0);
        io = 1'b0; we = 1'b0;

        repeat (2) @(posedge clk_sys);
        #1;
        check("final_sb", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iigs_shadow_ctrl.md
Name: iigs_shadow_ctrl

Overview:
Parametrised memory-side controller for the IIgs core. It decodes each CPU access into fast RAM, ROM or slow (E0/E1) RAM. Shadowed writes to banks 00/01 are queued in a FIFO and replayed into slow RAM at the 1 MHz slot rate. Direct E0/E1 accesses stall the CPU through cpu_wait until they complete in order behind pending shadow writes. It sits between the iigs core bus and the fastram/slowram/rom ports.

Parameters:
RAMSIZE, 20, number of 64K fast RAM banks (banks 0..RAMSIZE-1); legal range 2..127
SLOW_DIV, 14, clk_sys cycles per slow-RAM slot; must be >= 3
FIFO_AW, 2, log2 of shadow FIFO depth (depth 4 by default)

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
fast_ce  in  1  one-clk_sys strobe marking a valid CPU bus cycle
bank  in  8  CPU bank
addr  in  16  CPU address
we  in  1  CPU write
dout  in  8  CPU write data
shadow  in  8  shadow register, inhibit bits active-high
io  in  1  I/O space access (C000-C0FF), excluded from all RAM decode
rdrom  in  1  language-card read-ROM
lc_we  in  1  language-card write enable
cpu_wait  out  1  stall CPU
fastram_ce  out  1  fast RAM select (combinational)
rom_ce  out  1  ROM select (combinational)
slow_rdata  out  8  registered slow-RAM read data for CPU
slowram_addr  out  17  {bank[0], addr}
slowram_din  out  8  slow RAM write data
slowram_we  out  1  slow RAM write strobe
slowram_ce  out  1  slow RAM access strobe
slowram_q  in  8  slow RAM read data, valid one clk_sys after slowram_ce
fifo_level  out  FIFO_AW+1  queued shadow writes

Behaviour:
- Reset (async, reset_n=0): state IDLE; slot counter 0; FIFO empty; cpu_wait, slowram_ce, slowram_we = 0; slowram_addr, slowram_din, slow_rdata = 0; fifo_level = 0.
- Decode (combinational):
  - rom_ce = bank FE/FF, or bank 00 with addr >= C100 and rdrom.
  - fastram_ce = bank < RAMSIZE, !io, and (!rom_ce, or a lc_we write to D000-FFFF).
  - direct-slow = bank E0/E1 and !io.
- Shadow hit: write, bank 00/01, fastram_ce, and any of:
  - 0400-07FF with !shadow[0]
  - 0800-0BFF with !shadow[5]
  - 2000-3FFF with !shadow[1] (bank 01 additionally needs !shadow[4])
  - 4000-5FFF with !shadow[2] (bank 01 additionally needs !shadow[4])
  - bank 01 2000-9FFF with !shadow[3]
- Slot counter: counts 0..SLOW_DIV-1 and wraps. A slot fires when the count is SLOW_DIV-1.
- FIFO entry: {bank[0], addr, dout}, 25 bits.
  - A shadow hit on fast_ce with the FIFO not full enqueues the entry; the fast RAM write proceeds the same cycle with no wait.
  - FIFO full on a shadow hit: cpu_wait=1 from the next cycle. The entry is held and enqueued on the first cycle with space, including the cycle of a dequeue; cpu_wait drops the cycle after enqueue.
- State machine (one slow access per slot):
  - IDLE: on a slot with FIFO non-empty, dequeue the head and drive slowram_ce=1, slowram_we=1, addr/din from the entry for that single cycle. On fast_ce with direct-slow, set cpu_wait=1 and latch addr/we/dout, then go to SLOW_PEND.
  - SLOW_PEND: the FIFO drains first, one entry per slot, to preserve write ordering. On the first slot with FIFO empty, issue the CPU access (ce=1, we=latched) and go to SLOW_DONE.
  - SLOW_DONE (1 cycle): on a read, slow_rdata <= slowram_q. Clear cpu_wait, go to IDLE.
  - CPU latency for a direct access is therefore up to (queued+1)*SLOW_DIV+1 clk_sys.
- Simultaneous events:
  - A slot and an enqueue in the same cycle: the dequeue is performed and fifo_level is unchanged.
  - An enqueue into an empty FIFO on a slot cycle is not issued in that slot.
- Mid-operation reset: all state is dropped immediately; queued writes are lost.
- A fast_ce while cpu_wait=1 is ignored; the core does not strobe while stalled.

Test Plan:
- Reset mid SLOW_PEND with 3 queued -> cpu_wait=0, fifo_level=0, slowram_ce=0 while reset_n=0.
- shadow=00, write 00:0400=5A -> fastram_ce=1 and no wait; within SLOW_DIV cycles slowram_ce=we=1, addr=00400, din=5A; fifo_level returns to 0.
- shadow=01, write 00:0400=11 -> no enqueue. Write 01:2000 with shadow=10 (bit4 set, bit3 clear) -> enqueued (SHR path), addr=12000.
- 5 back-to-back shadow writes, FIFO_AW=2 -> fifo_level reaches 4; the 5th raises cpu_wait until the first slot; all 5 appear at slowram in order.
- 2 queued writes then a read of E1:2000 -> slowram sees both writes then the read at addr=12000; slow_rdata=slowram_q; cpu_wait high for about 3*SLOW_DIV cycles.
- bank=00 addr=D000 write, rdrom=1, lc_we=1 -> rom_ce=1 and fastram_ce=1. bank=RAMSIZE -> fastram_ce=0.
